ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  RV32I instruction fetch stage: owns the PC, issues in-order requests to instruction memory,
//  buffers returned words with their PC, and presents them to decode (whose inst feeds imm_gen
//  and the control decoder). Handles branch/jump redirects with flush of in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  DEPTH       2              instruction buffer entries (power of 2, >=2); also max outstanding
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch address (word aligned, [1:0]=0)
//  imem_rsp_valid  in   1   response word valid (in order, >=1 cycle after accept)
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken; refetch from redirect_pc
//  redirect_pc     in   32  target; bits [1:0] ignored (forced 0)
//  inst_valid      out  1   buffer head valid to decode
//  inst_ready      in   1   decode consumes head this cycle
//  inst            out  32  instruction word (to decoder / imm_gen)
//  inst_pc         out  32  PC of inst
// BEHAVIOUR
//  - Reset: pc=RESET_PC, buffer empty, outstanding=0, drop=0; imem_req_valid=0, inst_valid=0,
//    inst=0, inst_pc=0 in the reset cycle; first request may assert the cycle after rst falls.
//  - imem_req_addr = pc. Accept = req_valid & req_ready -> pc<=pc+4 (wraps 32'hFFFF_FFFC->0),
//    outstanding+1, request PC pushed to an in-flight PC queue (DEPTH entries).
//  - Credit: req_valid=1 only if !rst, !redirect_valid, and outstanding+count < DEPTH,
//    so every accepted fetch has a guaranteed buffer slot; rsp never back-pressured.
//  - Response (rsp_valid): if drop>0 -> discard, drop-1, outstanding-1; else push
//    {data, head of PC queue} into buffer, outstanding-1. Same-cycle accept+response legal.
//  - Output: inst/inst_pc/inst_valid driven from buffer head (registered storage, no
//    rsp->inst comb path). Pop when inst_valid & inst_ready. Zero-latency bypass not allowed:
//    word accepted from memory in cycle N is visible earliest in cycle N+1.
//  - Full buffer with push and pop same cycle: both occur, count unchanged. Empty + pop ignored.
//  - Redirect (highest priority after rst): pc<={redirect_pc[31:2],2'b00}; buffer flushed
//    (count=0, inst_valid=0 next cycle); drop<=outstanding minus any response discarded or
//    pushed this cycle (that one is flushed too); PC queue cleared; req_valid=0 this cycle;
//    inst_ready in the redirect cycle has no effect on visible state.
//  - Back-to-back redirects: latest wins; drop accumulates correctly (never underflows).
//  - Redirect while drop>0: new drop = all currently outstanding.
//  - Reset mid-operation discards everything; late responses for pre-reset requests are a
//    system error (memory is reset together with this block).
//  - Throughput: 1 inst/cycle steady state with 1-cycle memory and inst_ready=1.
//  - Counters sized $clog2(DEPTH)+1 bits; no overflow reachable given credit rule.
// TESTING
//  1 Reset then 1-cycle memory, inst_ready=1 -> addrs 0,4,8,...; inst_pc matches; 1 inst/cycle.
//  2 inst_ready=0 for 10 cycles -> exactly DEPTH fetches issued, req_valid then low; on
//    release words drain in order 0,4 with no loss/duplicate.
//  3 Redirect to 32'h0000_0103 with 2 fetches in flight (3-cycle memory) -> both responses
//    dropped; next inst_pc=32'h0000_0100; no stale inst_valid.
//  4 Redirect in same cycle as rsp_valid and inst_ready -> response dropped, no pop effect,
//    req_valid=0 that cycle, fetch from target next cycle.
//  5 imem_req_ready random 50%, inst_ready random -> scoreboard: inst stream == sequential PCs
//    from RESET_PC, memory contents match, outstanding never > DEPTH.
//  6 pc=32'hFFFF_FFFC fetch -> next addr 32'h0000_0000; rst asserted mid-stream -> next
//    cycle inst_valid=0, req_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: owns the PC, issues in-order imem requests under a credit
// scheme, buffers returned words with their PC and flushes in-flight fetches on redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] buf_wr_q, buf_wr_d;
  logic [AW-1:0] buf_rd_q, buf_rd_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d;
  logic [AW-1:0] pq_rd_q, pq_rd_d;

  logic [31:0] buf_data_q [DEPTH];
  logic [31:0] buf_pc_q   [DEPTH];
  logic [31:0] pq_pc_q    [DEPTH];

  logic           accept;
  logic           pop;
  logic           rsp_take;
  logic           discard;
  logic           push;
  logic [CW1-1:0] credit_used;

  always_comb begin
    inst_valid = (count_q != '0);
    pop        = inst_valid & inst_ready & ~redirect_valid;
    // A head popped this cycle frees its slot now, which keeps 1 inst/cycle at DEPTH=2.
    credit_used    = CW1'(outstanding_q) + CW1'(count_q) - CW1'(pop);
    imem_req_valid = ~rst & ~redirect_valid & (credit_used < CW1'(DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    rsp_take       = imem_rsp_valid & (outstanding_q != '0);
    discard        = rsp_take & (drop_q != '0);
    push           = rsp_take & (drop_q == '0) & ~redirect_valid;
    inst           = inst_valid ? buf_data_q[buf_rd_q] : '0;
    inst_pc        = inst_valid ? buf_pc_q[buf_rd_q]   : '0;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    buf_wr_d      = buf_wr_q;
    buf_rd_d      = buf_rd_q;
    pq_wr_d       = pq_wr_q;
    pq_rd_d       = pq_rd_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response must be dropped.
      pc_d          = redirect_pc & 32'hFFFF_FFFC;
      outstanding_d = outstanding_q - CW'(rsp_take);
      drop_d        = outstanding_q - CW'(rsp_take);
      count_d       = '0;
      buf_wr_d      = '0;
      buf_rd_d      = '0;
      pq_wr_d       = '0;
      pq_rd_d       = '0;
    end else begin
      if (accept) begin
        pc_d    = pc_q + 32'd4;
        pq_wr_d = pq_wr_q + AW'(1);
      end
      if (push) begin
        buf_wr_d = buf_wr_q + AW'(1);
        pq_rd_d  = pq_rd_q + AW'(1);
      end
      if (pop) begin
        buf_rd_d = buf_rd_q + AW'(1);
      end
      if (discard) begin
        drop_d = drop_q - CW'(1);
      end
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      buf_wr_q      <= '0;
      buf_rd_q      <= '0;
      pq_wr_q       <= '0;
      pq_rd_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      buf_wr_q      <= buf_wr_d;
      buf_rd_q      <= buf_rd_d;
      pq_wr_q       <= pq_wr_d;
      pq_rd_q       <= pq_rd_d;
    end
  end

  // Storage needs no reset: visibility is governed by count_q and the queue pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      pq_pc_q[pq_wr_q] <= pc_q;
    end
    if (push && !rst) begin
      buf_data_q[buf_wr_q] <= imem_rsp_data;
      buf_pc_q[buf_wr_q]   <= pq_pc_q[pq_rd_q];
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: table of directed per-cycle vectors plus hand-written
// redirect, random-handshake and wrap/reset sequences against an in-order memory model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    int unsigned  due;
  } pend_t;

  typedef struct {
    logic        rst;
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic        z;
  } vec_t;

  pend_t       pend_q[$];
  logic [31:0] acc_q[$];
  int unsigned cyc;
  int unsigned mem_lat;
  int unsigned max_out;
  int          tests;
  int          failed;
  int          pops;
  int          acc_mark;
  logic        sb_en;
  logic [31:0] exp_pc;
  vec_t        vecs [21];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the memory response for this cycle and let combinational outputs settle.
  task automatic tick_pre();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q[0].addr);
    end
    #1;
  endtask

  // Update the memory model and scoreboard, then advance one clock.
  task automatic tick_post();
    int unsigned d;
    if (pend_q.size() > max_out) max_out = pend_q.size();
    if (imem_rsp_valid) void'(pend_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + mem_lat;
      if (pend_q.size() > 0 && pend_q[$].due > d) d = pend_q[$].due;
      pend_q.push_back('{imem_req_addr, d});
      acc_q.push_back(imem_req_addr);
    end
    if (sb_en && !rst && !redirect_valid && inst_valid && inst_ready) begin
      check("sb_inst_pc", inst_pc, exp_pc);
      check("sb_inst", inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_valid && !rst) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    sb_en          = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    pops    = 0;
    exp_pc  = RESET_PC;
    max_out = 0;
    acc_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; failed = 0; cyc = 0; pops = 0; max_out = 0;
    sb_en = 1'b0; exp_pc = RESET_PC; mem_lat = 1;
    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    //            rst   ir    rv    addr          iv    ipc           z
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0};
    for (int i = 11; i <= 17; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 1'b0};

    @(negedge clk);
    tick();

    // Streaming, reset mid-stream, then stalled decode with drain.
    for (int i = 0; i < 21; i++) begin
      rst        = vecs[i].rst;
      inst_ready = vecs[i].ir;
      tick_pre();
      check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].addr);
      check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      if (vecs[i].iv) begin
        check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].ipc);
        check($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].ipc));
      end
      if (vecs[i].z) begin
        check($sformatf("v%0d_inst_zero", i), inst, 32'h0);
        check($sformatf("v%0d_inst_pc_zero", i), inst_pc, 32'h0);
      end
      tick_post();
    end

    // Redirect with two fetches in flight on a 3-cycle memory.
    do_reset();
    mem_lat = 3;
    sb_en   = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick_pre();
    check("t3_redir_req_valid", 32'(imem_req_valid), 32'h0);
    acc_mark = acc_q.size();
    tick_post();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_pre();
      check("t3_no_stale_valid", 32'(inst_valid), 32'h0);
      tick_post();
    end
    for (int i = 0; i < 20 && pops < 3; i++) tick();
    check("t3_progress", 32'(pops >= 3), 32'h1);
    check("t3_first_addr", (acc_q.size() > acc_mark) ? acc_q[acc_mark] : 32'hDEAD_DEAD,
          32'h0000_0100);

    // Redirect coinciding with a response and a decode pop.
    do_reset();
    mem_lat = 1;
    sb_en   = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick_pre();
    check("t4_redir_req_valid", 32'(imem_req_valid), 32'h0);
    tick_post();
    redirect_valid = 1'b0;
    tick_pre();
    check("t4_after_inst_valid", 32'(inst_valid), 32'h0);
    check("t4_after_req_valid", 32'(imem_req_valid), 32'h1);
    check("t4_after_req_addr", imem_req_addr, 32'h0000_0200);
    tick_post();
    pops = 0;
    for (int i = 0; i < 8; i++) tick();
    check("t4_progress", 32'(pops >= 5), 32'h1);

    // Random memory and decode handshakes.
    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 1));
      mem_lat        = $urandom_range(1, 3);
      tick();
    end
    check("t5_max_outstanding", 32'(max_out <= DEPTH), 32'h1);
    check("t5_progress", 32'(pops >= 40), 32'h1);

    // Address wrap at the top of memory, then reset mid-stream.
    do_reset();
    sb_en          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    acc_mark = acc_q.size();
    for (int i = 0; i < 10; i++) tick();
    check("t6_wrap_addr0", (acc_q.size() > acc_mark) ? acc_q[acc_mark] : 32'hDEAD_DEAD,
          32'hFFFF_FFFC);
    check("t6_wrap_addr1", (acc_q.size() > acc_mark + 1) ? acc_q[acc_mark + 1] : 32'hDEAD_DEAD,
          32'h0000_0000);
    check("t6_progress", 32'(pops >= 4), 32'h1);
    rst = 1'b1;
    tick_pre();
    check("t6_rst_req_valid", 32'(imem_req_valid), 32'h0);
    tick_post();
    rst   = 1'b0;
    sb_en = 1'b0;
    tick_pre();
    check("t6_post_rst_inst_valid", 32'(inst_valid), 32'h0);
    check("t6_post_rst_req_addr", imem_req_addr, RESET_PC);
    check("t6_post_rst_req_valid", 32'(imem_req_valid), 32'h1);
    tick_post();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
